layer1_psum_collector: RTL and testbench

- Downstream consumer of the layer-1 combinational MAC array.
- Each accepted beat carries eight signed Q6.10 partial sums, one per output channel, for one 3x3 kernel tap.
- Accumulates KERNEL_TAPS beats per output pixel, adds a per-channel bias, then saturates and applies ReLU.
- Pushes the packed 8-channel result into a 2-entry output FIFO with a valid/ready interface toward the layer-1 result writer.

---
 rtl/layer1_psum_collector_if.sv | 33 +++
 rtl/layer1_psum_collector.sv | 124 ++++++++++++
 tb/tb_layer1_psum_collector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/layer1_psum_collector_if.sv
// Handshake bundle between the layer-1 MAC array, the psum collector and the result writer.
// The collector sits on the slave side; the producer/consumer pair drives the master side.
interface layer1_psum_collector_if #(
    parameter int WORDLENGTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [WORDLENGTH-1:0]  partial_channel1;
    logic signed [WORDLENGTH-1:0]  partial_channel2;
    logic signed [WORDLENGTH-1:0]  partial_channel3;
    logic signed [WORDLENGTH-1:0]  partial_channel4;
    logic signed [WORDLENGTH-1:0]  partial_channel5;
    logic signed [WORDLENGTH-1:0]  partial_channel6;
    logic signed [WORDLENGTH-1:0]  partial_channel7;
    logic signed [WORDLENGTH-1:0]  partial_channel8;
    logic                          out_valid;
    logic                          out_ready;
    logic [8*WORDLENGTH-1:0]       out_data;

    modport master (
        output in_valid, out_ready,
        output partial_channel1, partial_channel2, partial_channel3, partial_channel4,
        output partial_channel5, partial_channel6, partial_channel7, partial_channel8,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, out_ready,
        input  partial_channel1, partial_channel2, partial_channel3, partial_channel4,
        input  partial_channel5, partial_channel6, partial_channel7, partial_channel8,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/layer1_psum_collector.sv
// Layer-1 partial-sum collector: accumulates KERNEL_TAPS beats per pixel, adds bias,
// saturates + ReLU, and queues the packed 8-lane result in a 2-entry FIFO.
module layer1_psum_collector #(
    parameter int WORDLENGTH  = 16,
    parameter int KERNEL_TAPS = 9,
    parameter int ACC_WIDTH   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    layer1_psum_collector_if.slave  bus,
    input  logic [8*WORDLENGTH-1:0] bias_in,
    input  logic                    bias_load,
    output logic [3:0]              tap_count
);
    localparam int LANES = 8;
    localparam int BUS_W = LANES * WORDLENGTH;
    localparam logic [3:0] LAST_TAP = 4'(KERNEL_TAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WORDLENGTH - 1)) - 1);

    // Negative sums map to 0 under ReLU, so only the upper clamp needs an explicit bound.
    function automatic logic [WORDLENGTH-1:0] sat_relu(input logic signed [ACC_WIDTH-1:0] s);
        if (s < 0)
            return '0;
        else if (s > SAT_MAX)
            return {1'b0, {(WORDLENGTH-1){1'b1}}};
        else
            return s[WORDLENGTH-1:0];
    endfunction

    logic signed [WORDLENGTH-1:0] part      [LANES];
    logic signed [WORDLENGTH-1:0] bias_lane [LANES];
    logic signed [ACC_WIDTH-1:0]  acc       [LANES];
    logic signed [ACC_WIDTH-1:0]  acc_nxt   [LANES];
    logic signed [ACC_WIDTH-1:0]  sum_p0    [LANES];
    logic [BUS_W-1:0]             bias_reg;
    logic [BUS_W-1:0]             pix_p0;
    logic                         accept;
    logic                         last_tap;
    logic                         vld_p0;
    logic                         pop;
    logic [BUS_W-1:0]             fifo_mem  [2];
    logic                         wr_ptr;
    logic                         rd_ptr;
    logic [1:0]                   fifo_count;

    always_comb begin
        part[0] = bus.partial_channel1;
        part[1] = bus.partial_channel2;
        part[2] = bus.partial_channel3;
        part[3] = bus.partial_channel4;
        part[4] = bus.partial_channel5;
        part[5] = bus.partial_channel6;
        part[6] = bus.partial_channel7;
        part[7] = bus.partial_channel8;
    end

    // Stage p0: final-tap sum, bias add and saturation, all ahead of the FIFO write
    always_comb begin
        pix_p0 = '0;
        for (int i = 0; i < LANES; i++) begin
            bias_lane[i] = bias_reg[BUS_W-1-i*WORDLENGTH -: WORDLENGTH];
            acc_nxt[i]   = acc[i] + ACC_WIDTH'(part[i]);
            sum_p0[i]    = acc_nxt[i] + ACC_WIDTH'(bias_lane[i]);
            pix_p0[BUS_W-1-i*WORDLENGTH -: WORDLENGTH] = sat_relu(sum_p0[i]);
        end
    end

    assign bus.in_ready = !rst && (fifo_count != 2'd2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_tap     = (tap_count == LAST_TAP);
    assign vld_p0       = accept && last_tap;
    assign pop          = bus.out_valid && bus.out_ready;

    // Bias is read combinationally above, so a coincident bias_load only affects later pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_count <= '0;
            bias_reg  <= '0;
            for (int i = 0; i < LANES; i++)
                acc[i] <= '0;
        end else begin
            if (bias_load)
                bias_reg <= bias_in;
            if (accept) begin
                if (last_tap) begin
                    tap_count <= '0;
                    for (int i = 0; i < LANES; i++)
                        acc[i] <= '0;
                end else begin
                    tap_count <= tap_count + 4'd1;
                    for (int i = 0; i < LANES; i++)
                        acc[i] <= acc_nxt[i];
                end
            end
        end
    end

    // Stage p1: 2-entry result FIFO toward the writer
    always_ff @(posedge clk) begin
        if (vld_p0)
            fifo_mem[wr_ptr] <= pix_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (vld_p0)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({vld_p0, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_layer1_psum_collector.sv
// Scoreboard bench for layer1_psum_collector: directed windows push expected pixels,
// an independent monitor pops and compares on every output handshake.
module tb_layer1_psum_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] bias_in;
    logic         bias_load;
    logic [3:0]   tap_count;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q [$];

    layer1_psum_collector_if #(.WORDLENGTH(16)) bus ();

    layer1_psum_collector #(
        .WORDLENGTH (16),
        .KERNEL_TAPS(9),
        .ACC_WIDTH  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .bias_in  (bias_in),
        .bias_load(bias_load),
        .tap_count(tap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h expected=none", bus.out_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL out_data got=%h expected=%h", bus.out_data, e);
                end
            end
        end
    end

    task automatic drive_parts(input logic [127:0] p);
        bus.partial_channel1 = p[127:112];
        bus.partial_channel2 = p[111:96];
        bus.partial_channel3 = p[95:80];
        bus.partial_channel4 = p[79:64];
        bus.partial_channel5 = p[63:48];
        bus.partial_channel6 = p[47:32];
        bus.partial_channel7 = p[31:16];
        bus.partial_channel8 = p[15:0];
    endtask

    // Holds a beat until accepted; returns #1 after the accepting edge.
    task automatic beat(input logic [127:0] p, input logic ld);
        int   waited;
        logic took;
        waited        = 0;
        took          = 1'b0;
        bus.in_valid  = 1'b1;
        bias_load     = ld;
        drive_parts(p);
        while (!took) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (!took) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout got=stalled expected=accept");
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
        bias_load    = 1'b0;
        drive_parts('0);
    endtask

    task automatic run_window(input logic [127:0] p, input logic [127:0] exp,
                              input int gap, input logic load_last);
        exp_q.push_back(exp);
        for (int t = 0; t < 9; t++) begin
            beat(p, (t == 8) ? load_last : 1'b0);
            if (t == 7)
                chk("tap_count_before_last", {124'd0, tap_count}, 128'd8);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    task automatic load_bias(input logic [127:0] b);
        bias_in   = b;
        bias_load = 1'b1;
        @(posedge clk);
        #1;
        bias_load = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bias_in       = '0;
        bias_load     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_parts('0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("reset_out_data", bus.out_data, 128'd0);
        chk("reset_tap_count", {124'd0, tap_count}, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", {127'd0, bus.in_ready}, 128'd1);

        // 1: unit partials, bias 0, idle gaps between beats
        bus.out_ready = 1'b1;
        run_window({8{16'h0400}}, {8{16'h2400}}, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({8{16'h2400}});
        for (int t = 0; t < 9; t++) beat({8{16'h0400}}, 1'b0);
        chk("latency_out_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("latency_out_data", bus.out_data, {8{16'h2400}});
        chk("tap_count_wrap", {124'd0, tap_count}, 128'd0);
        @(posedge clk);
        #1;
        chk("drained_out_valid", {127'd0, bus.out_valid}, 128'd0);

        // 2: positive saturation
        load_bias({8{16'h0400}});
        run_window({8{16'h7000}}, {8{16'h7FFF}}, 0, 1'b0);

        // 3: ReLU on lane1, positive result on lane2
        load_bias({16'h0400, 16'hFE00, 96'd0});
        run_window({16'hFC00, 16'h0200, 96'd0}, {16'h0000, 16'h1000, 96'd0}, 0, 1'b0);

        // 4: backpressure with a full FIFO
        load_bias('0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        run_window({8{16'h0400}}, {8{16'h2400}}, 0, 1'b0);
        run_window({8{16'h0800}}, {8{16'h4800}}, 0, 1'b0);
        chk("full_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("full_head_data", bus.out_data, {8{16'h2400}});
        fork
            run_window({8{16'h0C00}}, {8{16'h6C00}}, 0, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_tap_count", {124'd0, tap_count}, 128'd0);
                chk("stall_head_hold", bus.out_data, {8{16'h2400}});
                chk("stall_out_valid", {127'd0, bus.out_valid}, 128'd1);
                bus.out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // 5: bias_load coincident with final tap uses the old bias
        bias_in = {8{16'h0400}};
        run_window({8{16'h0400}}, {8{16'h2400}}, 0, 1'b1);
        run_window({8{16'h0400}}, {8{16'h2800}}, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // 6: reset mid-window discards accumulation and bias
        for (int t = 0; t < 4; t++) beat({8{16'h0400}}, 1'b0);
        chk("mid_window_tap_count", {124'd0, tap_count}, 128'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mid_reset_tap_count", {124'd0, tap_count}, 128'd0);
        rst = 1'b0;
        run_window({8{16'h0400}}, {8{16'h2400}}, 0, 1'b0);

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
